// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: run state, log entry layout and widths.
package store_monitor_pkg;

   localparam int MEM_W       = 16;
   localparam int CYCLE_W     = 32;
   localparam int LOG_ENTRY_W = 2 * MEM_W + CYCLE_W;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } mon_state_e;

   typedef struct packed {
      logic [MEM_W-1:0]   addr;
      logic [MEM_W-1:0]   data;
      logic [CYCLE_W-1:0] cycle;
   } log_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// Generic show-ahead FIFO for trace logs: registered occupancy, no fall-through.
module store_log_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_push,
   input  logic [DATA_W-1:0]           i_din,
   input  logic                        i_pop,
   output logic [DATA_W-1:0]           o_head,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [$clog2(DEPTH):0]      o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_push;
   logic              w_do_pop;

   // A push into a full FIFO only lands when the head leaves on the same edge.
   assign w_do_pop  = i_pop & (r_count != '0);
   assign w_do_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/store_monitor.sv
// End-of-run checker for the multicycle processor: classifies stores, times the run, logs stores.
module store_monitor
   import store_monitor_pkg::*;
#(
   parameter logic [15:0] PASS_ADDR      = 16'd84,
   parameter logic [15:0] PASS_DATA      = 16'd7,
   parameter logic [15:0] SCRATCH_ADDR   = 16'd80,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
   parameter int          LOG_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [15:0] dataadr,
   input  logic [15:0] writedata,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [31:0] cycle_count,
   output logic [15:0] store_count,
   output logic        overflow,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [15:0] log_addr,
   output logic [15:0] log_data,
   output logic [31:0] log_cycle
);

   localparam logic [31:0] LP_LAST_CYCLE = TIMEOUT_CYCLES - 32'd1;
   localparam int          CNT_W         = $clog2(LOG_DEPTH) + 1;

   mon_state_e         r_state;
   logic               r_done;
   logic               r_pass;
   logic               r_fail;
   logic               r_timeout;
   logic               r_overflow;
   logic [CYCLE_W-1:0] r_cycle;
   logic [MEM_W-1:0]   r_stores;

   logic               w_accept;
   logic               w_is_pass;
   logic               w_is_scratch;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_drop;
   logic [CNT_W-1:0]   w_count;
   log_entry_t         w_entry_in;
   log_entry_t         w_head;

   function automatic logic [MEM_W-1:0] sat_inc(input logic [MEM_W-1:0] v);
      return (v == '1) ? v : v + MEM_W'(1);
   endfunction

   assign w_accept     = (r_state == ST_RUN) & memwrite;
   assign w_is_pass    = (dataadr == PASS_ADDR) & (writedata == PASS_DATA);
   assign w_is_scratch = (dataadr == SCRATCH_ADDR);
   assign w_pop        = log_valid & log_ready;
   assign w_drop       = w_accept & w_full & ~w_pop;

   assign w_entry_in.addr  = dataadr;
   assign w_entry_in.data  = writedata;
   assign w_entry_in.cycle = r_cycle;

   // A store classified on the last allowed edge wins over the timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_timeout  <= 1'b0;
         r_overflow <= 1'b0;
         r_cycle    <= '0;
         r_stores   <= '0;
      end else if (r_state == ST_RUN) begin
         r_cycle <= r_cycle + CYCLE_W'(1);
         if (memwrite) begin
            r_stores <= sat_inc(r_stores);
            if (w_drop) r_overflow <= 1'b1;
            if (w_is_pass) begin
               r_state <= ST_PASS;
               r_done  <= 1'b1;
               r_pass  <= 1'b1;
            end else if (!w_is_scratch) begin
               r_state <= ST_FAIL;
               r_done  <= 1'b1;
               r_fail  <= 1'b1;
            end
         end else if (r_cycle == LP_LAST_CYCLE) begin
            r_state   <= ST_TIMEOUT;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
         end
      end
   end

   store_log_fifo #(
      .DATA_W (LOG_ENTRY_W),
      .DEPTH  (LOG_DEPTH)
   ) u_log (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_push  (w_accept),
      .i_din   (w_entry_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (!reset) assert (w_empty == (w_count == '0));
   end

   assign done        = r_done;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign timeout     = r_timeout;
   assign overflow    = r_overflow;
   assign cycle_count = r_cycle;
   assign store_count = r_stores;
   assign log_valid   = ~w_empty;
   assign log_addr    = log_valid ? w_head.addr  : '0;
   assign log_data    = log_valid ? w_head.data  : '0;
   assign log_cycle   = log_valid ? w_head.cycle : '0;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor with a scoreboard queue of expected log entries.
module tb_store_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [15:0] dataadr = '0;
   logic [15:0] writedata = '0;
   logic        log_ready = 1'b0;
   logic        done, pass, fail, timeout, overflow, log_valid;
   logic [31:0] cycle_count, log_cycle;
   logic [15:0] store_count, log_addr, log_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   store_monitor #(
      .PASS_ADDR      (16'd84),
      .PASS_DATA      (16'd7),
      .SCRATCH_ADDR   (16'd80),
      .TIMEOUT_CYCLES (32'd64),
      .LOG_DEPTH      (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .memwrite    (memwrite),
      .dataadr     (dataadr),
      .writedata   (writedata),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .cycle_count (cycle_count),
      .store_count (store_count),
      .overflow    (overflow),
      .log_valid   (log_valid),
      .log_ready   (log_ready),
      .log_addr    (log_addr),
      .log_data    (log_data),
      .log_cycle   (log_cycle)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pop the DUT will perform on the next edge is checked against the queue head.
   always @(negedge clk) begin
      if (!reset && log_valid && log_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL log_unexpected: got %0h/%0h/%0h expected nothing", log_addr, log_data, log_cycle);
         end else begin
            chk("log_entry", {log_addr, log_data, log_cycle}, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset(input int n);
      reset = 1'b1;
      memwrite = 1'b0;
      log_ready = 1'b0;
      exp_q.delete();
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic idle(input int n);
      memwrite = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      memwrite = 1'b1;
      dataadr = a;
      writedata = d;
      @(posedge clk);
      #1 memwrite = 1'b0;
   endtask

   task automatic expect_log(input logic [15:0] a, input logic [15:0] d, input logic [31:0] c);
      exp_q.push_back({a, d, c});
   endtask

   task automatic drain;
      log_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (!log_valid) break;
      end
      chk("drain_valid_low", log_valid, 1'b0);
      chk("drain_queue_empty", exp_q.size(), 0);
      log_ready = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_flags"}, {done, pass, fail, timeout, overflow, log_valid}, 6'b0);
      chk({tag, "_cycle"}, cycle_count, 32'd0);
      chk({tag, "_stores"}, store_count, 16'd0);
      chk({tag, "_log"}, {log_addr, log_data, log_cycle}, 64'd0);
   endtask

   initial begin
      // Pass run
      do_reset(2);
      chk_idle_outputs("reset");
      idle(5);
      expect_log(16'd80, 16'd3, 32'd5);
      store(16'd80, 16'd3);
      chk("scratch_run", {done, fail, log_valid}, 3'b001);
      idle(3);
      expect_log(16'd84, 16'd7, 32'd9);
      store(16'd84, 16'd7);
      chk("pass_flags", {done, pass, fail, timeout}, 4'b1100);
      chk("pass_cycle", cycle_count, 32'd10);
      chk("pass_stores", store_count, 16'd2);
      store(16'd96, 16'd1);
      idle(3);
      chk("pass_frozen_cycle", cycle_count, 32'd10);
      chk("pass_ignore_store", {store_count, fail}, {16'd2, 1'b0});
      drain();

      // Wrong data at the pass address
      do_reset(1);
      expect_log(16'd84, 16'd5, 32'd0);
      store(16'd84, 16'd5);
      chk("wrongdata_flags", {done, pass, fail}, 3'b101);
      store(16'd84, 16'd7);
      chk("wrongdata_after", {pass, store_count}, {1'b0, 16'd1});
      drain();

      // Illegal address
      do_reset(1);
      expect_log(16'd80, 16'd1, 32'd0);
      store(16'd80, 16'd1);
      expect_log(16'd96, 16'd7, 32'd1);
      store(16'd96, 16'd7);
      chk("illegal_flags", {done, pass, fail}, 3'b101);
      chk("illegal_stores", store_count, 16'd2);
      drain();

      // Timeout with no stores
      do_reset(1);
      idle(63);
      chk("pre_timeout", {timeout, cycle_count}, {1'b0, 32'd63});
      idle(1);
      chk("timeout_flags", {done, pass, fail, timeout}, 4'b1001);
      chk("timeout_cycle", cycle_count, 32'd64);
      idle(5);
      chk("timeout_frozen", cycle_count, 32'd64);

      // Store on the last edge beats timeout
      do_reset(1);
      idle(63);
      expect_log(16'd84, 16'd7, 32'd63);
      store(16'd84, 16'd7);
      chk("lastedge_flags", {done, pass, timeout}, 3'b110);
      chk("lastedge_cycle", cycle_count, 32'd64);
      drain();

      // Overflow: six stores into a depth-4 log with no consumer
      do_reset(1);
      for (int k = 0; k < 6; k++) begin
         if (k < 4) expect_log(16'd80, 16'(k), 32'(k));
         store(16'd80, 16'(k));
      end
      chk("ovf_flags", {overflow, done}, 2'b10);
      chk("ovf_stores", store_count, 16'd6);
      drain();

      // Full log with simultaneous pop: pushes land, no overflow
      do_reset(1);
      for (int k = 0; k < 6; k++) begin
         expect_log(16'd80, 16'(k), 32'(k));
         log_ready = (k >= 4);
         store(16'd80, 16'(k));
      end
      chk("pushpop_overflow", overflow, 1'b0);
      chk("pushpop_stores", store_count, 16'd6);
      drain();

      // Reset mid-run
      do_reset(1);
      for (int k = 0; k < 3; k++) store(16'd80, 16'(k));
      do_reset(1);
      chk_idle_outputs("midreset");
      expect_log(16'd84, 16'd7, 32'd0);
      store(16'd84, 16'd7);
      chk("midreset_pass", {pass, store_count}, {1'b1, 16'd1});
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected $finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable end-of-run checker for the 16-bit multicycle processor. It sits directly downstream of the processor top level and consumes its external data-memory write port (memwrite, dataadr, writedata).
- Classifies every store as pass, allowed-scratch or fail.
- Counts cycles and enforces a timeout.
- Logs accepted stores in a FIFO that a host or bench drains over a valid/ready port.

Parameters:
- PASS_ADDR, 84, store address that ends the run.
- PASS_DATA, 7, data required at PASS_ADDR for a pass.
- SCRATCH_ADDR, 80, store address that is allowed without ending the run.
- TIMEOUT_CYCLES, 1000, run cycles before timeout. Legal range 2 to 2^32-1.
- LOG_DEPTH, 8, FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  1  processor store strobe.
- dataadr  in  16  store byte address.
- writedata  in  16  store data.
- done  out  1  run has ended (pass, fail or timeout); sticky.
- pass  out  1  correct terminal store seen; sticky.
- fail  out  1  illegal store seen; sticky.
- timeout  out  1  cycle limit reached; sticky.
- cycle_count  out  32  run cycles elapsed.
- store_count  out  16  stores accepted in RUN; saturates at 16'hFFFF.
- overflow  out  1  a log push was dropped; sticky.
- log_valid  out  1  log head is valid.
- log_ready  in  1  consumer pops the head when log_valid is also 1.
- log_addr  out  16  head entry: store address.
- log_data  out  16  head entry: store data.
- log_cycle  out  32  head entry: cycle_count at capture.

Behaviour:
- Reset (synchronous, active-high): state RUN. cycle_count=0, store_count=0. done, pass, fail, timeout, overflow all 0. FIFO empty, log_valid=0, log_addr/log_data/log_cycle=0. Reset overrides all other activity, including mid-run and in terminal states.
- States: RUN, PASS, FAIL, TIMEOUT. The last three are terminal and are left only by reset.
- Flags: done = state != RUN. pass/fail/timeout are 1 exactly in the matching state. All are registered and assert the cycle after the causing edge.
- RUN, every edge: cycle_count increments by 1.
- RUN, edge with memwrite=1 (store accepted), priority order:
  1. dataadr==PASS_ADDR and writedata==PASS_DATA -> PASS.
  2. dataadr==SCRATCH_ADDR -> stay in RUN.
  3. Anything else, including PASS_ADDR with wrong data -> FAIL.
- Every accepted store:
  - store_count increments (saturating).
  - Entry {dataadr, writedata, cycle_count pre-increment} is pushed, including the terminal store.
- Timeout: if no store is accepted on the edge where cycle_count == TIMEOUT_CYCLES-1, go to TIMEOUT. A store on that same edge is classified normally and takes priority over timeout.
- Terminal states: cycle_count and store_count freeze. memwrite is ignored and nothing is pushed. The FIFO can still be drained.
- FIFO:
  - Show-ahead: the log_* outputs reflect the head whenever log_valid=1.
  - No fall-through: a push into an empty FIFO raises log_valid on the next cycle.
  - Pop on log_valid & log_ready. Pop when empty is a no-op.
  - Push when full without a simultaneous pop: entry dropped, overflow set, store_count still increments, state classification unaffected.
  - Push when full with a simultaneous pop: both occur, occupancy unchanged.
  - Pointer wrap via LOG_DEPTH-modulo pointers plus an occupancy count (width clog2(LOG_DEPTH)+1).
- Inputs are sampled on the rising edge only; memwrite held high for N edges counts as N stores.

Decomposition:
- Shared package:
  - Monitor state enum (RUN, PASS, FAIL, TIMEOUT).
  - Log entry struct {addr[15:0], data[15:0], cycle[31:0]} and its 64-bit width constant.
  - Data/address width constant of 16.
- Sub-module store_log_fifo: parameterized by width and depth; synchronous reset; push/pop/full/empty/count plus a head output. Reusable for other trace logs.

Test Plan:
- Pass run: reset 2 cycles; store (80,3) at cycle 5, then (84,7) at cycle 9 -> pass=1 and done=1 from cycle 10. store_count=2. Drain yields (80,3,5) then (84,7,9). fail=0.
- Wrong data: store (84,5) -> fail=1 next cycle. pass=0. Later stores (84,7) are ignored and store_count stays 1.
- Illegal address: stores (80,1) then (96,7) -> fail=1. Log holds 2 entries.
- Timeout: TIMEOUT_CYCLES=64, no stores -> timeout=1 after edge 64, cycle_count frozen at 64. A second run with store (84,7) on edge 64 -> pass=1, timeout=0.
- Overflow and simultaneous push/pop: LOG_DEPTH=4, six (80,k) stores with log_ready=0 -> overflow=1, store_count=6, drain returns k=0..3. Repeat with log_ready=1 and stores back-to-back -> no overflow, order preserved.
- Reset mid-run: after 3 scratch stores, assert reset for 1 cycle -> all outputs 0, log_valid=0. A subsequent (84,7) store -> pass with store_count=1.
